// File: rtl/relu_maxpool_stream.sv
// Streaming ReLU followed by 2x2/stride-2 max pooling and shift-and-saturate requantisation.
// Accepts one raster-order pixel per cycle and emits one pooled byte per 2x2 window.
module relu_maxpool_stream #(
    parameter int unsigned MAP   = 26,
    parameter int unsigned SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        frame_err
);

    localparam int unsigned CW   = (MAP > 2) ? $clog2(MAP) : 1;
    localparam int unsigned HALF = MAP / 2;
    localparam int unsigned AW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST_POS = CW'(MAP - 1);

    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [14:0]   r_pair;
    logic [14:0]   r_linebuf [HALF];
    logic [7:0]    r_out_data;
    logic          r_out_valid;
    logic          r_out_last;
    logic          r_frame_err;

    logic          w_accept;
    logic [14:0]   w_relu;
    logic [14:0]   w_hmax;
    logic [14:0]   w_lb_rd;
    logic [14:0]   w_pool;
    logic [14:0]   w_scaled;
    logic [7:0]    w_sat;
    logic          w_at_end;
    logic          w_misalign;
    logic          w_emit;
    logic [AW-1:0] w_lb_idx;

    assign in_ready  = !(r_out_valid && !out_ready);
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign frame_err = r_frame_err;

    always_comb begin
        w_accept   = in_valid && in_ready;
        w_relu     = in_data[15] ? 15'd0 : in_data[14:0];
        w_hmax     = (w_relu > r_pair) ? w_relu : r_pair;
        w_lb_idx   = AW'(r_col >> 1);
        w_lb_rd    = r_linebuf[w_lb_idx];
        w_pool     = (w_lb_rd > w_hmax) ? w_lb_rd : w_hmax;
        w_scaled   = w_pool >> SHIFT;
        w_sat      = (w_scaled > 15'd255) ? 8'hFF : w_scaled[7:0];
        w_at_end   = (r_row == LAST_POS) && (r_col == LAST_POS);
        w_misalign = w_accept && in_last && !w_at_end;
        w_emit     = w_accept && !w_misalign && r_row[0] && r_col[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row       <= '0;
            r_col       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_misalign) begin
                r_row       <= '0;
                r_col       <= '0;
                r_frame_err <= 1'b1;
            end else if (w_accept) begin
                if (w_at_end && !in_last) begin
                    r_frame_err <= 1'b1;
                end
                if (r_col == LAST_POS) begin
                    r_col <= '0;
                    r_row <= (r_row == LAST_POS) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            // Accept implies the output slot is empty or draining this cycle.
            if (w_emit) begin
                r_out_data  <= w_sat;
                r_out_valid <= 1'b1;
                r_out_last  <= w_at_end;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    // Pair register and line buffer are always written before read; no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept && !w_misalign) begin
            if (!r_col[0]) begin
                r_pair <= w_relu;
            end else if (!r_row[0]) begin
                r_linebuf[w_lb_idx] <= w_hmax;
            end
        end
    end

endmodule

// File: doc/relu_maxpool_stream.md
RELU_MAXPOOL_STREAM -- requirements
Module: relu_maxpool_stream

Interface
REQ-001 SHALL have parameter MAP, default 26, meaning square input feature-map side; it must be even and at least 2.
REQ-002 SHALL have parameter SHIFT, default 4, meaning right-shift applied to each pooled value before saturation.
REQ-003 SHALL have port clk  input  1  system clock; all logic sits in this single clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_data  input  16  signed conv result, raster order (row-major).
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_last  input  1  producer marks final pixel of the MAP×MAP frame.
REQ-008 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have port out_data  output  8  unsigned pooled, requantised pixel.
REQ-010 SHALL have port out_valid  output  1  out_data is valid.
REQ-011 SHALL have port out_last  output  1  marks pooled pixel (MAP/2-1, MAP/2-1).
REQ-012 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-013 SHALL have port frame_err  output  1  sticky flag: in_last was misaligned with the frame position.

Function
REQ-014 SHALL treat a beat as accepted when in_valid and in_ready are both high, and as delivered when out_valid and out_ready are both high.
REQ-015 SHALL drive in_ready = !(out_valid && !out_ready) combinationally.
REQ-016 SHALL track input position with counters row and col, each 0..MAP-1, advanced only on an accepted beat.
- col wraps MAP-1 -> 0 and increments row.
- row wraps MAP-1 -> 0 at frame end.
REQ-017 SHALL apply ReLU to every accepted beat: negative -> 0; otherwise the value is kept and treated as 15-bit unsigned.
REQ-018 SHALL handle even col by holding the ReLU value in a pair register.
REQ-019 SHALL handle odd col by forming hmax = max(pair register, current ReLU value).
REQ-020 SHALL, on even row with odd col, write hmax into line buffer entry col/2; the line buffer has MAP/2 entries of 15 bits.
REQ-021 SHALL, on odd row with odd col, compute p = max(linebuf[col/2], hmax) and register it to the output stage.
REQ-022 SHALL compute out_data = (p >> SHIFT) when that is ≤255, else 255 (saturate); SHIFT=0 is legal.
REQ-023 SHALL assert out_valid on the clock edge that accepts the odd/odd input beat, giving one-cycle latency.
REQ-024 SHALL hold out_data, out_valid and out_last stable until delivered.
REQ-025 SHALL allow a new result to load in the same cycle an old one is delivered, sustaining 1 beat/cycle throughput with no bubbles while out_ready=1.
REQ-026 SHALL assert out_last together with out_valid for the result from input (MAP-1, MAP-1); each frame yields exactly (MAP/2)² outputs.
REQ-027 SHALL handle an accepted in_last at a position other than (MAP-1, MAP-1) as follows:
- set frame_err=1;
- force row and col to 0 (resync);
- emit no output for that beat.
REQ-028 SHALL handle position (MAP-1, MAP-1) accepted without in_last as follows:
- set frame_err=1;
- produce that output normally, including out_last;
- wrap the counters.
REQ-029 SHALL keep frame_err set until rst_n is asserted; no other clear exists.
REQ-030 SHALL begin the next frame immediately after (MAP-1, MAP-1) with no idle cycle required.
REQ-031 SHALL never have line buffer read and write of the same entry in one cycle (even and odd rows are disjoint); no bypass is needed.

Reset
REQ-032 SHALL, on rst_n low and regardless of clk, set out_valid=0, out_last=0, out_data=0, frame_err=0, row=0 and col=0.
REQ-033 SHALL read in_ready=1 during and after reset.
REQ-034 SHALL treat the line buffer and pair register as don't-care after reset, since they are always written before being read.
REQ-035 SHALL, when reset is asserted mid-frame, discard the partial frame; the next accepted beat is treated as pixel (0,0).

Verification
REQ-036 SHALL cover a ramp frame: MAP=26, SHIFT=4, in_data = row*26+col, out_ready=1. Required response:
- 169 outputs;
- output (i,j) = min(255, (52i+2j+27)>>4), first value 1;
- out_last only on output 169.
REQ-037 SHALL cover ReLU: a frame of all -5 (0xFFFB) -> 169 outputs of 0x00.
REQ-038 SHALL cover saturation: 2×2 window {0, 7, 100, 16000}, SHIFT=4 -> 255; window max 4095 -> 255; window max 4080 -> 255; window max 4079 -> 254.
REQ-039 SHALL cover backpressure: out_ready low for 10 cycles at pooled pixel 5. Required response:
- in_ready low for exactly those cycles while out_valid=1;
- out_data stable throughout;
- no output lost or duplicated;
- 169 total.
REQ-040 SHALL cover misalignment: in_last asserted on beat 100 -> frame_err=1, no output for beat 100; the next beat is treated as (0,0) and a full correct frame follows.
REQ-041 SHALL cover reset mid-frame: rst_n pulsed low after 300 beats -> out_valid=0 immediately; a following full frame yields 169 correct outputs and frame_err=0.
